// File: rtl/sys_bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: transfer direction codes,
// grant owner and arbiter state encodings, and the round-robin pick helper.
`ifndef RW_READ
`define RW_READ 1'b0
`endif
`ifndef RW_WRITE
`define RW_WRITE 1'b1
`endif

package sys_bus_arbiter_pkg;

    localparam logic RW_READ  = `RW_READ;
    localparam logic RW_WRITE = `RW_WRITE;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_XFER  = 2'd2
    } arb_state_e;

    // Round-robin choice: on a tie the port that did not win last time goes next.
    function automatic grant_e rr_pick(input logic i_pend, input logic d_pend, input grant_e last);
        if (i_pend && d_pend) begin
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_pend) begin
            return GRANT_D;
        end
        return GRANT_I;
    endfunction

endpackage

// File: rtl/sys_bus_arbiter_req_latch.sv
// Per-port request holder: a pending flag plus the direction, address and
// store data captured with the port's one-cycle request strobe.
module arb_req_latch #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          strobe_i,
    input  logic          rw_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          clr_i,
    output logic          pending_o,
    output logic          rw_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o
);

    logic          pending_q, pending_d;
    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          accept;

    // A strobe on an already-pending port is dropped unless that request retires on the same edge.
    assign accept = strobe_i && (!pending_q || clr_i);

    // Pending flag next state: clear on retirement, a simultaneous new request wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        if (accept) begin
            pending_d = 1'b1;
        end
    end

    // Pending flag register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Request fields are only meaningful while pending, so they carry no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            rw_q    <= rw_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign pending_o = pending_q;
    assign rw_o      = rw_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;

endmodule

// File: rtl/sys_bus_arbiter.sv
// System-memory port arbiter between the I-cache and D-cache controllers:
// captures request strobes, grants round-robin, runs one memory transaction
// at a time and steers each returned beat to the owning cache.
module sys_bus_arbiter
    import sys_bus_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_LEN = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_strobe,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_last,
    input  logic          d_strobe,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_last,
    output logic [DW-1:0] rdata,
    output logic          sys_strobe,
    output logic          sys_rw,
    output logic [AW-1:0] sys_addr,
    output logic [DW-1:0] sys_wdata,
    input  logic          sys_ready,
    input  logic [DW-1:0] sys_rdata
);

    localparam int             BCW       = $clog2(BURST_LEN) + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

    arb_state_e    state_q, state_d;
    grant_e        grant_q, grant_d;
    grant_e        last_grant_q, last_grant_d;
    grant_e        winner;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    logic          i_ready_q, i_ready_d, i_last_q, i_last_d;
    logic          d_ready_q, d_ready_d, d_last_q, d_last_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          sys_strobe_q, sys_strobe_d;
    logic          sys_rw_q, sys_rw_d;
    logic [AW-1:0] sys_addr_q, sys_addr_d;
    logic [DW-1:0] sys_wdata_q, sys_wdata_d;

    logic          i_clr, d_clr;
    logic          i_pend, d_pend;
    logic          i_rw_q, d_rw_q;
    logic [AW-1:0] i_addr_q, d_addr_q;
    logic [DW-1:0] i_wdata_q, d_wdata_q;

    // I-cache only ever reads, so its direction and store data are constants.
    arb_req_latch #(.AW(AW), .DW(DW)) u_i_req (
        .clock     (clock),
        .reset     (reset),
        .strobe_i  (i_strobe),
        .rw_i      (RW_READ),
        .addr_i    (i_addr),
        .wdata_i   ('0),
        .clr_i     (i_clr),
        .pending_o (i_pend),
        .rw_o      (i_rw_q),
        .addr_o    (i_addr_q),
        .wdata_o   (i_wdata_q)
    );

    arb_req_latch #(.AW(AW), .DW(DW)) u_d_req (
        .clock     (clock),
        .reset     (reset),
        .strobe_i  (d_strobe),
        .rw_i      (d_rw),
        .addr_i    (d_addr),
        .wdata_i   (d_wdata),
        .clr_i     (d_clr),
        .pending_o (d_pend),
        .rw_o      (d_rw_q),
        .addr_o    (d_addr_q),
        .wdata_o   (d_wdata_q)
    );

    assign winner = rr_pick(i_pend, d_pend, last_grant_q);

    // Next-state and registered-output logic for the grant/issue/transfer sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        i_ready_d    = 1'b0;
        i_last_d     = 1'b0;
        d_ready_d    = 1'b0;
        d_last_d     = 1'b0;
        rdata_d      = rdata_q;
        sys_strobe_d = 1'b0;
        sys_rw_d     = sys_rw_q;
        sys_addr_d   = sys_addr_q;
        sys_wdata_d  = sys_wdata_q;
        i_clr        = 1'b0;
        d_clr        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (i_pend || d_pend) begin
                    grant_d = winner;
                    if (winner == GRANT_D) begin
                        sys_rw_d    = d_rw_q;
                        sys_addr_d  = d_addr_q;
                        sys_wdata_d = d_wdata_q;
                    end else begin
                        sys_rw_d    = i_rw_q;
                        sys_addr_d  = i_addr_q;
                        sys_wdata_d = i_wdata_q;
                    end
                    sys_strobe_d = 1'b1;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_XFER;
            end
            ARB_XFER: begin
                if (sys_ready) begin
                    rdata_d    = sys_rdata;
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (grant_q == GRANT_I) begin
                        i_ready_d = 1'b1;
                    end else begin
                        d_ready_d = 1'b1;
                    end
                    if ((sys_rw_q == RW_WRITE) || (beat_cnt_q == LAST_BEAT)) begin
                        if (grant_q == GRANT_I) begin
                            i_last_d = 1'b1;
                            i_clr    = 1'b1;
                        end else begin
                            d_last_d = 1'b1;
                            d_clr    = 1'b1;
                        end
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        state_d      = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            beat_cnt_q   <= '0;
            i_ready_q    <= 1'b0;
            i_last_q     <= 1'b0;
            d_ready_q    <= 1'b0;
            d_last_q     <= 1'b0;
            rdata_q      <= '0;
            sys_strobe_q <= 1'b0;
            sys_rw_q     <= RW_READ;
            sys_addr_q   <= '0;
            sys_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            i_ready_q    <= i_ready_d;
            i_last_q     <= i_last_d;
            d_ready_q    <= d_ready_d;
            d_last_q     <= d_last_d;
            rdata_q      <= rdata_d;
            sys_strobe_q <= sys_strobe_d;
            sys_rw_q     <= sys_rw_d;
            sys_addr_q   <= sys_addr_d;
            sys_wdata_q  <= sys_wdata_d;
        end
    end

    assign i_ready    = i_ready_q;
    assign i_last     = i_last_q;
    assign d_ready    = d_ready_q;
    assign d_last     = d_last_q;
    assign rdata      = rdata_q;
    assign sys_strobe = sys_strobe_q;
    assign sys_rw     = sys_rw_q;
    assign sys_addr   = sys_addr_q;
    assign sys_wdata  = sys_wdata_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: memory responder, transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_sys_bus_arbiter;
    import sys_bus_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_strobe, d_strobe, d_rw, sys_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, sys_rdata;
    logic          i_ready, i_last, d_ready, d_last, sys_strobe, sys_rw;
    logic [DW-1:0] rdata, sys_wdata;
    logic [AW-1:0] sys_addr;

    sys_bus_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(BL)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_strobe   (i_strobe),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_last     (i_last),
        .d_strobe   (d_strobe),
        .d_rw       (d_rw),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_last     (d_last),
        .rdata      (rdata),
        .sys_strobe (sys_strobe),
        .sys_rw     (sys_rw),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_ready  (sys_ready),
        .sys_rdata  (sys_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- memory responder ----------------
    int            mem_delay = 0;
    int            stray_n   = 0;
    bit            mem_active;
    int            mem_gap, mem_beat, mem_beats;
    logic [AW-1:0] mem_addr;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a, input int beat);
        if (a == 32'h100) return 32'hA0 + DW'(beat);
        return a + DW'(beat) + 32'h1000;
    endfunction

    initial begin
        sys_ready  = 1'b0;
        sys_rdata  = '0;
        mem_active = 1'b0;
        forever begin
            @(negedge clock);
            #1;
            sys_ready = 1'b0;
            if (!reset) begin
                mem_active = 1'b0;
            end else if (mem_active) begin
                if (mem_gap > 0) begin
                    mem_gap--;
                end else begin
                    sys_ready = 1'b1;
                    sys_rdata = mem_data(mem_addr, mem_beat);
                    mem_beat++;
                    if (mem_beat == mem_beats) mem_active = 1'b0;
                end
            end else if (sys_strobe) begin
                mem_active = 1'b1;
                mem_gap    = mem_delay;
                mem_beat   = 0;
                mem_beats  = (sys_rw == RW_WRITE) ? 1 : BL;
                mem_addr   = sys_addr;
            end else if (stray_n > 0) begin
                sys_ready = 1'b1;
                sys_rdata = 32'h5555_5555;
                stray_n--;
            end
        end
    end

    // ---------------- reference model (transaction level) ----------------
    // Port 0 is the I-cache, port 1 the D-cache.
    bit            m_pend[2];
    logic          m_rw[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_wd[2];
    bit            m_busy, m_issue, m_clr0, m_clr1, m_conflict;
    int            m_owner, m_last_owner, m_left;
    logic          e_i_ready, e_i_last, e_d_ready, e_d_last, e_sys_strobe, e_sys_rw;
    logic [DW-1:0] e_rdata, e_sys_wdata;
    logic [AW-1:0] e_sys_addr;

    always @(posedge clock) begin
        cyc++;
        m_clr0 = 1'b0;
        m_clr1 = 1'b0;
        if (!reset) begin
            m_pend[0] = 1'b0; m_pend[1] = 1'b0;
            m_busy = 1'b0; m_issue = 1'b0; m_last_owner = 0; m_left = 0;
            e_i_ready = 1'b0; e_i_last = 1'b0; e_d_ready = 1'b0; e_d_last = 1'b0;
            e_sys_strobe = 1'b0; e_sys_rw = RW_READ;
            e_rdata = '0; e_sys_addr = '0; e_sys_wdata = '0;
        end else begin
            e_i_ready = 1'b0; e_i_last = 1'b0; e_d_ready = 1'b0; e_d_last = 1'b0;
            e_sys_strobe = 1'b0;
            if (m_busy && m_issue) begin
                m_issue = 1'b0;
            end else if (m_busy) begin
                if (sys_ready) begin
                    e_rdata = sys_rdata;
                    if (m_owner == 0) e_i_ready = 1'b1; else e_d_ready = 1'b1;
                    m_left--;
                    if (m_left == 0) begin
                        if (m_owner == 0) begin e_i_last = 1'b1; m_clr0 = 1'b1; end
                        else begin e_d_last = 1'b1; m_clr1 = 1'b1; end
                        m_last_owner = m_owner;
                        m_busy = 1'b0;
                    end
                end
            end else if (m_pend[0] || m_pend[1]) begin
                if (m_pend[0] && m_pend[1]) m_owner = 1 - m_last_owner;
                else m_owner = m_pend[1] ? 1 : 0;
                m_busy       = 1'b1;
                m_issue      = 1'b1;
                m_left       = (m_rw[m_owner] == RW_WRITE) ? 1 : BL;
                e_sys_strobe = 1'b1;
                e_sys_rw     = m_rw[m_owner];
                e_sys_addr   = m_addr[m_owner];
                e_sys_wdata  = m_wd[m_owner];
            end
            if (m_clr0) m_pend[0] = 1'b0;
            if (m_clr1) m_pend[1] = 1'b0;
            if (i_strobe) begin
                m_conflict = m_pend[0];
                check("proto_i_strobe_while_pending", m_conflict, 0);
                if (!m_conflict) begin
                    m_pend[0] = 1'b1; m_rw[0] = RW_READ; m_addr[0] = i_addr; m_wd[0] = '0;
                end
            end
            if (d_strobe) begin
                m_conflict = m_pend[1];
                check("proto_d_strobe_while_pending", m_conflict, 0);
                if (!m_conflict) begin
                    m_pend[1] = 1'b1; m_rw[1] = d_rw; m_addr[1] = d_addr; m_wd[1] = d_wdata;
                end
            end
        end
    end

    // ---------------- per-cycle compare and event log ----------------
    logic [31:0] i_data[$], d_data[$], s_addr[$], s_rw[$], s_wd[$], s_edge[$];
    int          i_cnt, d_cnt, i_last_cnt, d_last_cnt, i_last_at, i_last_edge, d_last_with_ready;
    logic [31:0] d_wd_at_beat;

    always @(posedge clock) begin
        #1;
        check("i_ready", i_ready, e_i_ready);
        check("i_last", i_last, e_i_last);
        check("d_ready", d_ready, e_d_ready);
        check("d_last", d_last, e_d_last);
        check("rdata", rdata, e_rdata);
        check("sys_strobe", sys_strobe, e_sys_strobe);
        check("sys_rw", sys_rw, e_sys_rw);
        check("sys_addr", sys_addr, e_sys_addr);
        check("sys_wdata", sys_wdata, e_sys_wdata);
        if (i_ready) begin i_data.push_back(rdata); i_cnt++; end
        if (i_last) begin i_last_cnt++; i_last_edge = cyc; i_last_at = i_cnt; end
        if (d_ready) begin d_data.push_back(rdata); d_cnt++; d_wd_at_beat = sys_wdata; end
        if (d_last) begin d_last_cnt++; if (d_ready) d_last_with_ready++; end
        if (sys_strobe) begin
            s_addr.push_back(sys_addr); s_rw.push_back({31'b0, sys_rw});
            s_wd.push_back(sys_wdata); s_edge.push_back(cyc + 1);
        end
    end

    task automatic clear_logs();
        i_data.delete(); d_data.delete(); s_addr.delete(); s_rw.delete(); s_wd.delete(); s_edge.delete();
        i_cnt = 0; d_cnt = 0; i_last_cnt = 0; d_last_cnt = 0; i_last_at = 0; i_last_edge = 0;
        d_last_with_ready = 0; d_wd_at_beat = '0;
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_last(input string name, input int want_i, input int want_d, input int budget);
        int t = 0;
        while ((i_last_cnt < want_i || d_last_cnt < want_d) && t < budget) begin
            @(negedge clock);
            t++;
        end
        check({name, "_i_last_count"}, i_last_cnt, want_i);
        check({name, "_d_last_count"}, d_last_cnt, want_d);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_ibeats(input string name, input int want, input int budget);
        int t = 0;
        while (i_cnt < want && t < budget) begin
            @(negedge clock);
            t++;
        end
        check({name, "_i_beats_reached"}, i_cnt, want);
    endtask

    // ---------------- directed scenarios ----------------
    int n_edge;
    int lat;

    initial begin
        reset = 1'b0; i_strobe = 1'b0; i_addr = '0; d_strobe = 1'b0; d_rw = RW_READ;
        d_addr = '0; d_wdata = '0;
        clear_logs();
        repeat (3) @(negedge clock);
        check("rst_sys_strobe", sys_strobe, 0);
        check("rst_sys_rw", sys_rw, RW_READ);
        check("rst_sys_addr", sys_addr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_last", d_last, 0);
        reset = 1'b1;
        @(negedge clock);

        // Tie straight after reset: D first, then I.
        clear_logs(); mem_delay = 1;
        i_strobe = 1'b1; i_addr = 32'h300;
        d_strobe = 1'b1; d_rw = RW_READ; d_addr = 32'h200;
        @(negedge clock);
        i_strobe = 1'b0; d_strobe = 1'b0;
        wait_last("tie1", 1, 1, 80);
        check("tie1_first_addr", qget(s_addr, 0), 32'h200);
        check("tie1_second_addr", qget(s_addr, 1), 32'h300);
        check("tie1_d_beat0", qget(d_data, 0), 32'h1200);
        check("tie1_i_beat3", qget(i_data, 3), 32'h1303);

        // Lone I read of 0x100.
        clear_logs(); mem_delay = 0;
        i_strobe = 1'b1; i_addr = 32'h100; n_edge = cyc + 1;
        @(negedge clock);
        i_strobe = 1'b0; i_addr = '0;
        wait_last("iread", 1, 0, 40);
        lat = int'(qget(s_edge, 0)) - n_edge;
        check("iread_strobe_latency", lat, 2);
        check("iread_strobe_count", s_addr.size(), 1);
        check("iread_sys_addr", qget(s_addr, 0), 32'h100);
        check("iread_sys_rw", qget(s_rw, 0), RW_READ);
        check("iread_beats", i_cnt, 4);
        check("iread_beat0", qget(i_data, 0), 32'hA0);
        check("iread_beat1", qget(i_data, 1), 32'hA1);
        check("iread_beat2", qget(i_data, 2), 32'hA2);
        check("iread_beat3", qget(i_data, 3), 32'hA3);
        check("iread_last_on_4th", i_last_at, 4);
        check("iread_no_d_ready", d_cnt, 0);

        // D write with memory answering three cycles late.
        clear_logs(); mem_delay = 3;
        d_strobe = 1'b1; d_rw = RW_WRITE; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        @(negedge clock);
        d_strobe = 1'b0; d_rw = RW_READ; d_addr = '0; d_wdata = '0;
        wait_last("dwrite", 0, 1, 40);
        check("dwrite_sys_rw", qget(s_rw, 0), RW_WRITE);
        check("dwrite_sys_addr", qget(s_addr, 0), 32'h40);
        check("dwrite_wdata_at_strobe", qget(s_wd, 0), 32'hDEADBEEF);
        check("dwrite_wdata_at_beat", d_wd_at_beat, 32'hDEADBEEF);
        check("dwrite_single_beat", d_cnt, 1);
        check("dwrite_last_with_ready", d_last_with_ready, 1);
        check("dwrite_no_i_ready", i_cnt, 0);

        // Second tie after D won last: I goes first.
        clear_logs(); mem_delay = 0;
        i_strobe = 1'b1; i_addr = 32'h300;
        d_strobe = 1'b1; d_rw = RW_READ; d_addr = 32'h280;
        @(negedge clock);
        i_strobe = 1'b0; d_strobe = 1'b0;
        wait_last("tie2", 1, 1, 80);
        check("tie2_first_addr", qget(s_addr, 0), 32'h300);
        check("tie2_second_addr", qget(s_addr, 1), 32'h280);
        check("tie2_i_beat0", qget(i_data, 0), 32'h1300);
        check("tie2_d_beat3", qget(d_data, 3), 32'h1283);

        // D request arriving on the 2nd beat of an I fill.
        clear_logs(); mem_delay = 0;
        i_strobe = 1'b1; i_addr = 32'h100;
        @(negedge clock);
        i_strobe = 1'b0;
        wait_ibeats("ovl", 1, 20);
        d_strobe = 1'b1; d_rw = RW_READ; d_addr = 32'h200;
        @(negedge clock);
        d_strobe = 1'b0;
        wait_last("ovl", 1, 1, 80);
        lat = int'(qget(s_edge, 1)) - i_last_edge;
        check("ovl_d_strobe_gap", lat, 2);
        check("ovl_d_addr", qget(s_addr, 1), 32'h200);
        check("ovl_i_beat1", qget(i_data, 1), 32'hA1);
        check("ovl_i_beat3", qget(i_data, 3), 32'hA3);
        check("ovl_d_beat0", qget(d_data, 0), 32'h1200);

        // Stray memory beat while idle.
        clear_logs(); stray_n = 1;
        repeat (4) @(negedge clock);
        check("stray_no_i_ready", i_cnt, 0);
        check("stray_no_d_ready", d_cnt, 0);
        check("stray_rdata_held", rdata, 32'h1203);
        i_strobe = 1'b1; i_addr = 32'h100;
        @(negedge clock);
        i_strobe = 1'b0;
        wait_last("stray", 1, 0, 40);
        check("stray_fill_last_on_4th", i_last_at, 4);

        // Reset in the middle of an I fill.
        clear_logs();
        i_strobe = 1'b1; i_addr = 32'h100;
        @(negedge clock);
        i_strobe = 1'b0;
        wait_ibeats("midrst", 2, 20);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_i_ready", i_ready, 0);
        check("midrst_i_last", i_last, 0);
        check("midrst_sys_strobe", sys_strobe, 0);
        check("midrst_rdata", rdata, 0);
        check("midrst_sys_addr", sys_addr, 0);
        reset = 1'b1;
        @(negedge clock);
        clear_logs();
        i_strobe = 1'b1; i_addr = 32'h100;
        @(negedge clock);
        i_strobe = 1'b0;
        wait_last("postrst", 1, 0, 40);
        check("postrst_beats", i_cnt, 4);
        check("postrst_beat0", qget(i_data, 0), 32'hA0);
        check("postrst_beat3", qget(i_data, 3), 32'hA3);
        check("postrst_last_on_4th", i_last_at, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
